// File: rtl/dpsm_cv_scan_pkg.sv
// dpsm_cv_scan_pkg
// Purpose : shared FSM state type and grid-size helpers for the DPSM
//           change-vector scanner (dpsm_cv_scan) and its interface.
// Contents: state_e (ACC/SCAN/DIV), total_cells(), idx_width(), count_width().
package dpsm_cv_scan_pkg;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_SCAN = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Number of cells in an (l+1)x(l+1) grid.
  function automatic int unsigned total_cells(int unsigned l);
    return (l + 1) * (l + 1);
  endfunction

  // Width of a cell index; never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // Mismatch counter holds 1..total+1 without wrapping.
  function automatic int unsigned count_width(int unsigned total);
    return $clog2(total + 2);
  endfunction

endpackage

// File: rtl/dpsm_cv_scan_if.sv
// dpsm_cv_scan_if
// Purpose : groups the sample/beat inputs and result outputs of dpsm_cv_scan.
// Signals : en, s_valid, vqx, vqy, rpsm, qrs, cv1_flag (towards the scanner);
//           y, y_valid, busy, drop (from the scanner).
// Modports: slave = scanner side, master = driver side.
interface dpsm_cv_scan_if
  import dpsm_cv_scan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned L          = 6
);
  localparam int unsigned TOTAL = total_cells(L);

  logic                        en;
  logic                        s_valid;
  logic [DATA_WIDTH-1:0]       vqx;
  logic [DATA_WIDTH-1:0]       vqy;
  logic [TOTAL*DATA_WIDTH-1:0] rpsm;
  logic                        qrs;
  logic                        cv1_flag;
  logic [DATA_WIDTH-1:0]       y;
  logic                        y_valid;
  logic                        busy;
  logic                        drop;

  modport slave (
    input  en, s_valid, vqx, vqy, rpsm, qrs, cv1_flag,
    output y, y_valid, busy, drop
  );

  modport master (
    output en, s_valid, vqx, vqy, rpsm, qrs, cv1_flag,
    input  y, y_valid, busy, drop
  );

endinterface

// File: rtl/dpsm_cv_scan_div.sv
// dpsm_div
// Purpose : restoring divider, one quotient bit per enabled cycle.
//           dividend is 2*WIDTH bits; a quotient that does not fit in WIDTH
//           bits raises sat (quotient is then meaningless).
// Ports   : clk, rst (sync, active-high), en (freezes all state when low),
//           start (load operands), dividend, divisor (must be non-zero),
//           done (one-cycle pulse after WIDTH iterations), quotient, sat.
module dpsm_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic               sat
);
  localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNTW-1:0]  cnt_q;
  logic             run_q;
  logic             done_q;
  logic             sat_q;

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Remainder stays below divisor, so the difference always fits in WIDTH bits.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    ge    = trial >= {1'b0, divisor};
    diff  = trial[WIDTH-1:0] - divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= dividend[2*WIDTH-1:WIDTH];
        quo_q <= dividend[WIDTH-1:0];
        sat_q <= dividend[2*WIDTH-1:WIDTH] >= divisor;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= ge ? diff : trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ge};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;
  assign sat      = sat_q;

endmodule

// File: rtl/dpsm_cv_scan.sv
// dpsm_cv_scan
// Purpose : accumulates quantised (vqx,vqy) samples into an (L+1)^2 histogram
//           per beat; on qrs scans the map against reference rpsm, counts
//           differing cells (plus one) and reports y = count/cv1 in
//           Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS. Baseline beats set cv1.
// Ports   : clk, rst (sync, active-high), bus (dpsm_cv_scan_if.slave:
//           en, s_valid, vqx, vqy, rpsm, qrs, cv1_flag -> y, y_valid, busy, drop).
module dpsm_cv_scan
  import dpsm_cv_scan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned L          = 6,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  dpsm_cv_scan_if.slave  bus
);
  localparam int unsigned TOTAL = total_cells(L);
  localparam int unsigned IW    = idx_width(TOTAL);
  localparam int unsigned CW    = count_width(TOTAL);

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] map_q     [TOTAL];
  logic [DATA_WIDTH-1:0] rpsm_cell [TOTAL];
  logic [IW-1:0]         idx_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] cv1_q;
  logic [DATA_WIDTH-1:0] y_q;
  logic                  y_valid_q;
  logic                  drop_q;
  logic                  base_q;
  logic                  busy;

  logic                  in_range;
  logic [IW-1:0]         samp_idx;
  logic                  last;
  logic                  mismatch;
  logic [CW-1:0]         count_nxt;
  logic [2*DATA_WIDTH-1:0] dividend;
  logic                  div_start;
  logic                  div_done;
  logic                  div_sat;
  logic [DATA_WIDTH-1:0] div_quo;

  always_comb begin
    for (int unsigned i = 0; i < TOTAL; i++) begin
      rpsm_cell[i] = bus.rpsm[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    in_range  = (bus.vqx <= DATA_WIDTH'(L)) && (bus.vqy <= DATA_WIDTH'(L));
    samp_idx  = IW'(bus.vqy) * IW'(L + 1) + IW'(bus.vqx);
    last      = idx_q == IW'(TOTAL - 1);
    mismatch  = map_q[idx_q] != rpsm_cell[idx_q];
    count_nxt = count_q + CW'(mismatch);
    // Divider sees the count including the cell scanned this cycle.
    dividend  = {{(2*DATA_WIDTH-CW){1'b0}}, count_nxt} << FRAC_BITS;
    div_start = bus.en && (state_q == ST_SCAN) && last && !base_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.en) begin
      case (state_q)
        ST_ACC:  if (bus.qrs) state_d = ST_SCAN;
        ST_SCAN: if (last)    state_d = base_q ? ST_ACC : ST_DIV;
        ST_DIV:  if (div_done) state_d = ST_ACC;
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == ST_SCAN) || (state_q == ST_DIV);
  end

  // Histogram: accumulate in ACC, clear cell-by-cell during SCAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TOTAL; i++) map_q[i] <= '0;
    end else if (bus.en) begin
      if (state_q == ST_ACC) begin
        if (bus.s_valid && in_range && (map_q[samp_idx] != '1))
          map_q[samp_idx] <= map_q[samp_idx] + 1'b1;
      end else if (state_q == ST_SCAN) begin
        map_q[idx_q] <= '0;
      end
    end
  end

  // Scan bookkeeping and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      count_q   <= CW'(1);
      cv1_q     <= DATA_WIDTH'(1);
      y_q       <= '0;
      y_valid_q <= 1'b0;
      drop_q    <= 1'b0;
      base_q    <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      drop_q    <= 1'b0;
      if (bus.en) begin
        case (state_q)
          ST_ACC: begin
            if (bus.s_valid && !in_range) drop_q <= 1'b1;
            if (bus.qrs) begin
              base_q  <= bus.cv1_flag;
              count_q <= CW'(1);
              idx_q   <= '0;
            end
          end
          ST_SCAN: begin
            if (bus.s_valid || bus.qrs) drop_q <= 1'b1;
            count_q <= count_nxt;
            idx_q   <= idx_q + 1'b1;
            if (last && base_q) begin
              cv1_q     <= DATA_WIDTH'(count_nxt);
              y_q       <= DATA_WIDTH'(1) << FRAC_BITS;
              y_valid_q <= 1'b1;
            end
          end
          ST_DIV: begin
            if (bus.s_valid || bus.qrs) drop_q <= 1'b1;
            if (div_done) begin
              y_q       <= div_sat ? '1 : div_quo;
              y_valid_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  dpsm_div #(
    .WIDTH (DATA_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (cv1_q),
    .done     (div_done),
    .quotient (div_quo),
    .sat      (div_sat)
  );

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = busy;
  assign bus.drop    = drop_q;

endmodule

// File: tb/tb_dpsm_cv_scan.sv
// tb_dpsm_cv_scan
// Purpose : self-checking bench for dpsm_cv_scan (L=6, DATA_WIDTH=16,
//           FRAC_BITS=8) against a histogram/ratio model held in arrays.
module tb_dpsm_cv_scan;
  localparam int DW    = 16;
  localparam int LL    = 6;
  localparam int FB    = 8;
  localparam int NC    = (LL + 1) * (LL + 1);

  logic clk;
  logic rst;

  dpsm_cv_scan_if #(.DATA_WIDTH(DW), .L(LL)) bus ();

  dpsm_cv_scan #(
    .DATA_WIDTH (DW),
    .L          (LL),
    .FRAC_BITS  (FB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int unsigned mmap [NC];
  int unsigned ref_c [NC];
  int unsigned m_cv1 = 1;
  int unsigned m_y   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_rpsm();
    for (int i = 0; i < NC; i++) bus.rpsm[i*DW +: DW] = DW'(ref_c[i]);
  endtask

  task automatic sample(input int x, input int yv, input bit en_v);
    bit exp_drop;
    bus.s_valid = 1'b1;
    bus.vqx     = DW'(x);
    bus.vqy     = DW'(yv);
    bus.en      = en_v;
    @(posedge clk); #1;
    exp_drop = en_v && (x > LL || yv > LL);
    chk("drop_sample", bus.drop, exp_drop);
    if (en_v && !exp_drop && mmap[yv*(LL+1)+x] < 65535)
      mmap[yv*(LL+1)+x]++;
    bus.s_valid = 1'b0;
    bus.en      = 1'b1;
  endtask

  // One beat: qrs with cv1_flag, optional 5-cycle en-low window and an
  // optional s_valid+qrs injection while busy.
  task automatic beat(input bit flag, input int pause_at, input int inject_at);
    int unsigned cnt;
    int unsigned exp_y;
    int          exp_lat;
    int          edges;
    cnt = 1;
    for (int i = 0; i < NC; i++) begin
      if (mmap[i] != ref_c[i]) cnt++;
      mmap[i] = 0;
    end
    if (flag) begin
      m_cv1 = cnt;
      exp_y = 256;
      exp_lat = NC + 1;
    end else begin
      exp_y = (cnt * 256) / m_cv1;
      if (exp_y > 65535) exp_y = 65535;
      exp_lat = NC + DW + 2;
    end
    if (pause_at > 0) exp_lat += 5;
    m_y = exp_y;

    bus.qrs      = 1'b1;
    bus.cv1_flag = flag;
    @(posedge clk); #1;
    bus.qrs = 1'b0;
    edges = 1;
    chk("busy_after_qrs", bus.busy, 1'b1);
    while (bus.y_valid !== 1'b1 && edges < 300) begin
      if (pause_at > 0 && edges == pause_at)     bus.en = 1'b0;
      if (pause_at > 0 && edges == pause_at + 5) bus.en = 1'b1;
      if (inject_at > 0 && edges == inject_at) begin
        bus.s_valid = 1'b1;
        bus.vqx     = '0;
        bus.vqy     = '0;
        bus.qrs     = 1'b1;
      end
      @(posedge clk); #1;
      edges++;
      if (inject_at > 0 && edges == inject_at + 1) begin
        chk("drop_busy", bus.drop, 1'b1);
        bus.s_valid = 1'b0;
        bus.qrs     = 1'b0;
      end
    end
    chk("latency", edges, exp_lat);
    chk("y", bus.y, exp_y);
    @(posedge clk); #1;
    chk("y_valid_one_cycle", bus.y_valid, 1'b0);
    chk("busy_idle", bus.busy, 1'b0);
    chk("y_hold", bus.y, m_y);
  endtask

  task automatic reset_abort();
    int seen;
    bus.qrs      = 1'b1;
    bus.cv1_flag = 1'b0;
    @(posedge clk); #1;
    bus.qrs = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.y_valid === 1'b1) seen++;
    end
    chk("no_y_valid_after_rst", seen, 0);
    chk("busy_after_rst", bus.busy, 1'b0);
    chk("y_after_rst", bus.y, 0);
    for (int i = 0; i < NC; i++) mmap[i] = 0;
    m_cv1 = 1;
    m_y   = 0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.s_valid  = 1'b0;
    bus.vqx      = '0;
    bus.vqy      = '0;
    bus.qrs      = 1'b0;
    bus.cv1_flag = 1'b0;
    for (int i = 0; i < NC; i++) begin mmap[i] = 0; ref_c[i] = 0; end
    load_rpsm();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", bus.y, 0);
    chk("rst_y_valid", bus.y_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_drop", bus.drop, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Baseline: 3 distinct cells -> cv1 = 4, y = 1.0
    sample(0, 0, 1); sample(1, 0, 1); sample(2, 2, 1);
    beat(1'b1, 0, 0);
    chk("cv1_model_base", m_cv1, 4);

    // 7 distinct cells -> count 8, y = 2.0
    for (int i = 0; i < 7; i++) sample(i, 3, 1);
    beat(1'b0, 0, 0);

    // Reference cell 10 = 2 matches two samples; cell 11 differs -> y = 0.5
    ref_c[10] = 2; load_rpsm();
    sample(3, 1, 1); sample(3, 1, 1); sample(4, 1, 1);
    beat(1'b0, 0, 0);
    ref_c[10] = 0; load_rpsm();

    // Out-of-range samples, disabled sample, and injections while busy
    sample(7, 0, 1); sample(0, 7, 1); sample(1, 1, 0);
    sample(5, 5, 1);
    beat(1'b0, 0, 10);
    sample(6, 6, 1);
    beat(1'b0, 0, 58);

    // en low for 5 cycles mid-DIV
    sample(2, 4, 1); sample(4, 2, 1);
    beat(1'b0, 55, 0);

    // rst mid-SCAN aborts, then map empty and cv1 = 1 -> y = 1.0
    sample(1, 2, 1); sample(3, 3, 1);
    reset_abort();
    beat(1'b0, 0, 0);

    // Randomised beats
    for (int b = 0; b < 6; b++) begin
      int ns;
      for (int i = 0; i < NC; i++) ref_c[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      load_rpsm();
      ns = $urandom_range(0, 15);
      for (int s = 0; s < ns; s++)
        sample($urandom_range(0, 8), $urandom_range(0, 8), 1);
      beat((b == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
